// File: rtl/pipeline_ifp_gen_if.sv
// pipeline_ifp_gen_if: fetch request bus between the PC generator and its memory channels.
interface pipeline_ifp_gen_if #(
    parameter int XLEN = 64,
    parameter int NUM_CH = 2,
    parameter int EPOCH_W = 2
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic req_valid;
    logic [NUM_CH-1:0] req_ready;
    logic [XLEN-1:0] req_addr;
    logic [CH_W-1:0] req_ch;
    logic [EPOCH_W-1:0] req_epoch;
    modport master (output req_valid, req_addr, req_ch, req_epoch, input req_ready);
    modport slave (input req_valid, req_addr, req_ch, req_epoch, output req_ready);
endinterface

// File: rtl/pipeline_ifp_gen.sv
// pipeline_ifp_gen: sequential/redirected fetch PC generator with channel decode,
// redirect epoch tagging and sticky misaligned-target fault.
module pipeline_ifp_gen #(
    parameter int XLEN = 64,
    parameter int NUM_CH = 2,
    parameter logic [NUM_CH*XLEN-1:0] CH_BASE = {64'h8000_0000, 64'h0},
    parameter logic [XLEN-1:0] BOOT_ADDR = '0,
    parameter int EPOCH_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    pipeline_ifp_gen_if.master bus,
    output logic [XLEN-1:0] pc_IFP,
    output logic pc_valid,
    output logic misalign_fault
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;
    state_t state, state_nx;
    logic [XLEN-1:0] addr;
    logic [EPOCH_W-1:0] epoch;
    logic [CH_W-1:0] ch;
    logic redir, misal, valid, fire;
    // Bases ascend, so the last base not above the address wins.
    always_comb begin
        ch = '0;
        for (int i = 1; i < NUM_CH; i++)
            if (addr >= CH_BASE[i*XLEN +: XLEN]) ch = CH_W'(i);
    end
    always_comb begin
        redir = redirect_valid && state != BOOT;
        misal = redirect_target[1:0] != 2'b00;
        valid = state == FETCH && !stall;
        fire = valid && bus.req_ready[ch];
        state_nx = state == BOOT ? FETCH : redir ? (misal ? FAULT : FETCH) : state;
    end
    // A redirect overrides any same-cycle fire, so a stale fetch never reaches pc_IFP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            addr <= BOOT_ADDR;
            epoch <= '0;
            pc_IFP <= '0;
            pc_valid <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            state <= state_nx;
            pc_valid <= fire && !redir;
            if (redir) begin
                addr <= redirect_target;
                epoch <= epoch + 1'b1;
                misalign_fault <= misal;
            end else if (fire) begin
                addr <= addr + XLEN'(4);
                pc_IFP <= addr;
            end
        end
    end
    assign bus.req_valid = valid;
    assign bus.req_addr = addr;
    assign bus.req_ch = ch;
    assign bus.req_epoch = epoch;
endmodule

// File: doc/pipeline_ifp_gen.md
Name: pipeline_ifp_gen

Overview:
Parametrised instruction-fetch-prepare PC generator for the pipelined CPU core. It produces a sequential or redirected fetch address and routes it to one of NUM_CH memory channels (boot ROM, DRAM, ...) chosen by a base-address decoder. It issues the fetch over a per-channel valid/ready handshake and tracks a redirect epoch so that downstream stages can discard stale fetches. It also reports misaligned redirect targets.

Parameters:
XLEN, 64, address/PC width
NUM_CH, 2, number of fetch channels (1..8)
CH_BASE, {64'h8000_0000, 64'h0}, packed NUM_CH*XLEN base addresses, index 0 in LSBs; CH_BASE[0] must be 0; bases strictly ascending
BOOT_ADDR, 0, first fetch address after reset
EPOCH_W, 2, width of redirect epoch counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  pipeline stall; suppresses new requests
redirect_valid  in  1  branch/jump taken
redirect_target  in  XLEN  redirect address
req_ready  in  NUM_CH  per-channel accept
req_valid  out  1  fetch request valid
req_addr  out  XLEN  fetch address
req_ch  out  max(1,$clog2(NUM_CH))  selected channel
req_epoch  out  EPOCH_W  epoch tag of the current request
pc_IFP  out  XLEN  PC of the last accepted fetch
pc_valid  out  1  pc_IFP updated this cycle (1-cycle pulse)
misalign_fault  out  1  sticky fault flag, set when a redirect target has addr[1:0]!=0

Behaviour:
- Reset (reset=0, async): state=BOOT, req_addr=BOOT_ADDR, req_valid=0, pc_IFP=0, pc_valid=0, req_epoch=0, misalign_fault=0.
- States: BOOT, FETCH, FAULT.
- BOOT: one cycle after reset release with req_valid=0. Then go to FETCH unconditionally.
- FETCH: req_valid = !stall. fire = req_valid & req_ready[req_ch].
  - On fire: pc_IFP<=req_addr, pc_valid<=1 next cycle, req_addr<=req_addr+4 (mod 2^XLEN; wraps to 0).
  - No fire: req_addr, req_ch and req_epoch are held stable while req_valid=1.
- stall: req_valid=0 combinationally. State, req_addr and pc_IFP hold. pc_valid=0 on the following cycle.
- Redirect: highest priority in FETCH and FAULT, and accepted even while stall=1.
  - req_addr<=redirect_target and req_epoch<=req_epoch+1 (wraps).
  - Any fire in the same cycle is discarded: pc_IFP is not updated and pc_valid=0 next cycle.
  - A pending unaccepted request is abandoned; this is the only case where the address may change under valid.
  - If redirect_target[1:0]!=0: state<=FAULT, misalign_fault<=1, req_addr<=target.
- FAULT: req_valid=0. Leave only on a redirect with an aligned target, which returns to FETCH and clears misalign_fault. A misaligned redirect stays in FAULT and still increments the epoch.
- Redirect in BOOT: ignored.
- Channel decode (combinational on req_addr): req_ch = highest i with req_addr >= CH_BASE[i]. Comparison is unsigned, full XLEN.
- Latency: a redirect is issued as a request 1 cycle after redirect_valid. Sequential throughput is 1 fetch/cycle when ready stays high.
- pc_valid is a registered pulse, 1 cycle after fire.

Test Plan:
- Reset release, req_ready all 1, no stall → BOOT for 1 cycle; then req_addr=0,4,8 on ch0; pc_IFP follows 1 cycle later with pc_valid=1 each cycle.
- req_ready[0]=0 for 3 cycles at addr 0x8 → req_valid=1, req_addr=0x8 stable, pc_valid=0; fires on the 4th cycle, then 0xC.
- redirect_target=0x8000_0000 in the same cycle as a fire at 0x10 → pc_IFP not updated to 0x10; next request is 0x8000_0000 with req_ch=1 and epoch incremented by 1.
- stall=1 with redirect_target=0x40 → req_valid=0 during the stall; on release the first request is 0x40 with the new epoch.
- redirect_target=0x42 → misalign_fault=1, req_valid=0 indefinitely; redirect to 0x100 → fault clears and a fetch at 0x100 follows; epoch has incremented twice.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC then one fire → next req_addr=0, req_ch=0; drop reset low mid-stall → all outputs at reset values immediately.
